// File: rtl/ov5640_cfg_sequencer.sv
// rtl/ov5640_cfg_sequencer.sv - OV5640 register configuration sequencer
//
// Purpose: once the power-up timing block raises cfg_start, walk the
// synchronous configuration ROM. Each entry is either an SCCB register write
// or a millisecond delay (reg_addr == DLY_ADDR). The outcome is reported to
// the capture pipeline through cfg_done / cfg_err.
//
// Ports:
//   sys_clk, sys_rst    clock, asynchronous active-high reset
//   cfg_start           level start, sampled only while idle
//   rom_addr/rom_data   ROM index out; entry {reg_addr, reg_data} returns one cycle later
//   sccb_req/addr/wdata write request to the SCCB master, held until sccb_done
//   sccb_done/nack      completion pulse; nack qualified by done
//   cfg_busy/done/err   status; done and err are sticky until reset
//   cfg_err_idx         ROM index of the entry that was NACKed
//
// Build macro: CFG_RETRY_EN - when defined, a NACKed write is retried up to
// MAX_RETRY extra times (after a 1-cycle gap) before the sequence aborts.
module ov5640_cfg_sequencer #(
  parameter int          CFG_NUM     = 256,
  parameter int          IDX_W       = 8,
  parameter int          CLK_FREQ_HZ = 100000000,
  parameter logic [15:0] DLY_ADDR    = 16'hFFFF,
  parameter int          MAX_RETRY   = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cfg_start,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [23:0]      rom_data,
  output logic             sccb_req,
  output logic [15:0]      sccb_addr,
  output logic [7:0]       sccb_wdata,
  input  logic             sccb_done,
  input  logic             sccb_nack,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_err,
  output logic [IDX_W-1:0] cfg_err_idx
);

  localparam int MS_CYC = (CLK_FREQ_HZ / 1000 > 0) ? CLK_FREQ_HZ / 1000 : 1;
  localparam int CNT_W  = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_ROM_WAIT, S_DECODE, S_WRITE,
    S_DELAY, S_NEXT, S_DONE, S_ERROR, S_RETRY
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rom_addr_q, rom_addr_d;
  logic               req_q, req_d;
  logic [15:0]        addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   err_idx_q, err_idx_d;
  logic [7:0]         ms_left_q, ms_left_d;
  logic [CNT_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic               retry_left;

`ifdef CFG_RETRY_EN
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RTY_W-1:0]   retry_cnt_q, retry_cnt_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) retry_cnt_q <= '0;
    else         retry_cnt_q <= retry_cnt_d;
  end

  assign retry_left = (retry_cnt_q < RTY_W'(MAX_RETRY));
`else
  // Retry count is meaningless without the retry feature; keep it referenced.
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY != 0);
  assign retry_left       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rom_addr_d = rom_addr_q;
    req_d      = req_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    ms_left_d  = ms_left_q;
    cyc_cnt_d  = cyc_cnt_q;
`ifdef CFG_RETRY_EN
    retry_cnt_d = retry_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        rom_addr_d = idx_q;
        state_d    = S_ROM_WAIT;
      end

      // ROM output for the new address lands on the next edge.
      S_ROM_WAIT: state_d = S_DECODE;

      S_DECODE: begin
`ifdef CFG_RETRY_EN
        retry_cnt_d = '0;
`endif
        if (rom_data[23:8] == DLY_ADDR) begin
          ms_left_d = rom_data[7:0];
          cyc_cnt_d = '0;
          state_d   = (rom_data[7:0] == 8'd0) ? S_NEXT : S_DELAY;
        end else begin
          addr_d  = rom_data[23:8];
          wdata_d = rom_data[7:0];
          req_d   = 1'b1;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (sccb_done) begin
          req_d = 1'b0;
          if (!sccb_nack) begin
            state_d = S_NEXT;
          end else if (retry_left) begin
`ifdef CFG_RETRY_EN
            retry_cnt_d = retry_cnt_q + RTY_W'(1);
            state_d     = S_RETRY;
`endif
          end else begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
            busy_d    = 1'b0;
            state_d   = S_ERROR;
          end
        end
      end

`ifdef CFG_RETRY_EN
      // One idle cycle with sccb_req low, then the same write again.
      S_RETRY: begin
        req_d   = 1'b1;
        state_d = S_WRITE;
      end
`endif

      S_DELAY: begin
        if (cyc_cnt_q == CNT_W'(MS_CYC - 1)) begin
          cyc_cnt_d = '0;
          ms_left_d = ms_left_q - 8'd1;
          if (ms_left_q == 8'd1) state_d = S_NEXT;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
      end

      S_NEXT: begin
        if (idx_q == IDX_W'(CFG_NUM - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end

      // Terminal until reset.
      S_DONE, S_ERROR: state_d = state_q;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rom_addr_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      ms_left_q  <= '0;
      cyc_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rom_addr_q <= rom_addr_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      ms_left_q  <= ms_left_d;
      cyc_cnt_q  <= cyc_cnt_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign sccb_req    = req_q;
  assign sccb_addr   = addr_q;
  assign sccb_wdata  = wdata_q;
  assign cfg_busy    = busy_q;
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;
  assign cfg_err_idx = err_idx_q;

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// tb/tb_ov5640_cfg_sequencer.sv - self-checking bench for ov5640_cfg_sequencer
module tb_ov5640_cfg_sequencer;
  localparam int CFG_NUM   = 4;
  localparam int CLK_HZ    = 20000;
  localparam int MS        = CLK_HZ / 1000;
  localparam int MAX_RETRY = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_data = '0;
  logic        sccb_req;
  logic [15:0] sccb_addr;
  logic [7:0]  sccb_wdata;
  logic        sccb_done = 1'b0;
  logic        sccb_nack = 1'b0;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [7:0]  cfg_err_idx;

  ov5640_cfg_sequencer #(
    .CFG_NUM(CFG_NUM), .IDX_W(8), .CLK_FREQ_HZ(CLK_HZ),
    .DLY_ADDR(16'hFFFF), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_start(cfg_start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_req(sccb_req), .sccb_addr(sccb_addr), .sccb_wdata(sccb_wdata),
    .sccb_done(sccb_done), .sccb_nack(sccb_nack),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .cfg_err_idx(cfg_err_idx)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic [23:0] rom [0:255];
  always @(posedge sys_clk) rom_data <= rom[rom_addr];

  // Per-request response plan, written by the stimulus, read by the responder.
  int  plan_lat [0:63];
  bit  plan_nk  [0:63];
  int  plan_n = 0;
  bit  spur_en = 1'b0;

  typedef struct {
    logic [23:0] ad;
    int          req_cyc;
    int          done_cyc;
    bit          nk;
  } wr_t;

  wr_t log_q[$];
  int  stab_bad = 0;
  int  resp_ptr = 0;
  int  resp_cnt = 0;
  bit  resp_nk  = 1'b0;
  bit  resp_act = 1'b0;
  bit  spur_done = 1'b0;

  // SCCB slave model: logs each request, answers after the planned latency.
  always @(negedge sys_clk) begin
    sccb_done = 1'b0;
    sccb_nack = 1'b0;
    if (sys_rst) begin
      resp_act  = 1'b0;
      resp_ptr  = 0;
      stab_bad  = 0;
      spur_done = 1'b0;
      log_q.delete();
    end else if (sccb_req) begin
      if (!resp_act) begin
        resp_act = 1'b1;
        if (resp_ptr < plan_n) begin
          resp_cnt = plan_lat[resp_ptr];
          resp_nk  = plan_nk[resp_ptr];
        end else begin
          resp_cnt = 10;
          resp_nk  = 1'b0;
        end
        resp_ptr++;
        log_q.push_back('{ad: {sccb_addr, sccb_wdata}, req_cyc: cyc, done_cyc: 0, nk: resp_nk});
      end else if ({sccb_addr, sccb_wdata} !== log_q[log_q.size()-1].ad) begin
        stab_bad++;
      end
      if (resp_cnt == 0) begin
        sccb_done = 1'b1;
        sccb_nack = resp_nk;
        resp_act  = 1'b0;
        log_q[log_q.size()-1].done_cyc = cyc;
      end else begin
        resp_cnt--;
      end
    end else if (spur_en && !spur_done && log_q.size() == 1 && cyc == log_q[0].done_cyc + 20) begin
      // Stray NACK pulse while no write is outstanding.
      sccb_done = 1'b1;
      sccb_nack = 1'b1;
      spur_done = 1'b1;
    end
  end

  int errors = 0;
  int checks = 0;
  int nacks [0:CFG_NUM-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge sys_clk);
    sys_rst   = 1'b1;
    cfg_start = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk({nm, " rst req"}, {31'd0, sccb_req}, 0);
    chk({nm, " rst busy"}, {31'd0, cfg_busy}, 0);
    chk({nm, " rst done"}, {31'd0, cfg_done}, 0);
    chk({nm, " rst err"}, {31'd0, cfg_err}, 0);
    chk({nm, " rst addr"}, {8'd0, sccb_addr, sccb_wdata}, 0);
    chk({nm, " rst idx"}, {16'd0, rom_addr, cfg_err_idx}, 0);
    sys_rst = 1'b0;
  endtask

  // Runs one full sequence against the model built from rom[] and nacks[].
  task automatic run_case(input string nm, input int lat_fix, input bit drop_start);
    logic [23:0] exp_q[$];
    bit exp_err = 1'b0;
    int exp_eidx = 0;
    int allowed;
    int att;
    int n = 0;
    int nlog;

    do_reset(nm);
    plan_n = 0;
    for (int i = 0; i < CFG_NUM; i++) begin
      if (rom[i][23:8] != 16'hFFFF) begin
        for (int k = 0; k <= nacks[i]; k++) begin
          plan_nk[plan_n]  = (k < nacks[i]);
          plan_lat[plan_n] = (lat_fix > 0) ? lat_fix : int'($urandom_range(0, 12));
          plan_n++;
        end
      end
    end

`ifdef CFG_RETRY_EN
    allowed = MAX_RETRY + 1;
`else
    allowed = 1;
`endif
    for (int i = 0; i < CFG_NUM; i++) begin
      if (rom[i][23:8] == 16'hFFFF) continue;
      att = (nacks[i] < allowed) ? nacks[i] + 1 : allowed;
      repeat (att) exp_q.push_back(rom[i]);
      if (nacks[i] >= allowed) begin
        exp_err  = 1'b1;
        exp_eidx = i;
        break;
      end
    end

    cfg_start = 1'b1;
    while (!(cfg_done === 1'b1 || cfg_err === 1'b1) && n < 20000) begin
      @(negedge sys_clk);
      n++;
      if (drop_start && log_q.size() > 0) cfg_start = 1'b0;
    end
    chk({nm, " finished in time"}, {31'd0, n < 20000}, 1);
    repeat (40) @(negedge sys_clk);

    nlog = log_q.size();
    chk({nm, " write count"}, nlog, exp_q.size());
    for (int i = 0; i < nlog && i < exp_q.size(); i++)
      chk($sformatf("%s write %0d", nm, i), {8'd0, log_q[i].ad}, {8'd0, exp_q[i]});
    for (int i = 1; i < nlog; i++) begin
      int gap = log_q[i].req_cyc - log_q[i-1].done_cyc;
      if (log_q[i-1].nk) chk($sformatf("%s retry gap %0d", nm, i), gap, 2);
      else chk($sformatf("%s idle gap %0d=%0d", nm, i, gap), {31'd0, gap - 1 >= 3}, 1);
    end
    chk({nm, " stable"}, stab_bad, 0);
    chk({nm, " done"}, {31'd0, cfg_done}, {31'd0, !exp_err});
    chk({nm, " err"}, {31'd0, cfg_err}, {31'd0, exp_err});
    chk({nm, " err idx"}, {24'd0, cfg_err_idx}, exp_err ? exp_eidx : 0);
    chk({nm, " busy"}, {31'd0, cfg_busy}, 0);

    // Terminal state must ignore a fresh start edge.
    cfg_start = 1'b0;
    repeat (3) @(negedge sys_clk);
    cfg_start = 1'b1;
    repeat (30) @(negedge sys_clk);
    chk({nm, " no restart"}, log_q.size(), nlog);
    chk({nm, " done sticky"}, {31'd0, cfg_done}, {31'd0, !exp_err});
  endtask

  task automatic load_base();
    rom[0] = 24'h300882;
    rom[1] = 24'h310303;
    rom[2] = 24'h3017FF;
    rom[3] = 24'h3018FF;
    for (int i = 0; i < CFG_NUM; i++) nacks[i] = 0;
  endtask

  initial begin
    int gap_d;
    int gap_p;
    int n;
    for (int i = 0; i < 256; i++) rom[i] = '0;

    load_base();
    run_case("basic", 10, 1'b0);

    load_base();
    rom[1] = 24'hFFFF05;
    spur_en = 1'b1;
    run_case("delay5", 10, 1'b0);
    spur_en = 1'b0;
    if (log_q.size() >= 3) begin
      gap_d = log_q[1].req_cyc - log_q[0].done_cyc;
      gap_p = log_q[2].req_cyc - log_q[1].done_cyc;
      chk($sformatf("delay5 length %0d vs %0d", gap_d, gap_p + 4 + 5 * MS),
          {31'd0, gap_d >= gap_p + 4 + 5 * MS - 2 && gap_d <= gap_p + 4 + 5 * MS + 2}, 1);
    end else begin
      chk("delay5 log size", log_q.size(), 3);
    end

    load_base();
    rom[1] = 24'hFFFF00;
    run_case("delay0", 10, 1'b0);
    if (log_q.size() >= 3) begin
      gap_d = log_q[1].req_cyc - log_q[0].done_cyc;
      gap_p = log_q[2].req_cyc - log_q[1].done_cyc;
      chk("delay0 skip gap", gap_d, gap_p + 4);
    end else begin
      chk("delay0 log size", log_q.size(), 3);
    end

    load_base();
    nacks[2] = 1;
    run_case("nack2", 10, 1'b0);

    load_base();
    nacks[1] = 2;
    run_case("nack1x2", 10, 1'b0);

    load_base();
    nacks[1] = 4;
    run_case("nack1x4", 10, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < CFG_NUM; i++) begin
        if ($urandom_range(0, 3) == 0)
          rom[i] = {16'hFFFF, 8'($urandom_range(0, 2))};
        else
          rom[i] = {16'(16'h3000 + $urandom_range(0, 16'h0FFF)), 8'($urandom)};
        nacks[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      end
      run_case($sformatf("rand%0d", r), 0, 1'(r % 2));
    end

    // Reset while the write for index 2 is outstanding.
    load_base();
    do_reset("midrst");
    plan_n = 0;
    cfg_start = 1'b1;
    n = 0;
    while (log_q.size() < 3 && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("midrst reached idx2", log_q.size(), 3);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("midrst req drop", {31'd0, sccb_req}, 0);
    chk("midrst busy", {31'd0, cfg_busy}, 0);
    chk("midrst flags", {30'd0, cfg_done, cfg_err}, 0);
    chk("midrst addr", {8'd0, sccb_addr, sccb_wdata}, 0);
    chk("midrst idx", {16'd0, rom_addr, cfg_err_idx}, 0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    n = 0;
    while (log_q.size() < 1 && n < 5000) begin
      @(negedge sys_clk);
      n++;
    end
    chk("midrst restart count", log_q.size(), 1);
    if (log_q.size() >= 1) chk("midrst first write", {8'd0, log_q[0].ad}, {8'd0, rom[0]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
